// File: rtl/ledpanel_scan_ctrl.sv
// ledpanel_scan_ctrl: BCM scan controller for a 32x16 1:8 RGB LED panel; `LEDPANEL_TEST_PATTERN_EN adds a column test pattern
module ledpanel_scan_ctrl #(
  parameter int SHIFT_DIV = 50,
  parameter int COL_BITS = 5,
  parameter int ROW_BITS = 3,
  parameter int PLANES = 4,
  parameter int BASE_OE_TICKS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
`ifdef LEDPANEL_TEST_PATTERN_EN
  input  logic test_mode,
`endif
  output logic rd_en,
  output logic [ROW_BITS+COL_BITS-1:0] rd_addr,
  input  logic [6*PLANES-1:0] rd_data,
  output logic frame_done,
  output logic [2:0] led_rgb1,
  output logic [2:0] led_rgb2,
  output logic [ROW_BITS-1:0] led_abc,
  output logic led_clk,
  output logic led_latch,
  output logic led_oe
);
  localparam int CW = SHIFT_DIV > 1 ? $clog2(SHIFT_DIV) : 1;
  localparam int PW = PLANES > 1 ? $clog2(PLANES) : 1;
  localparam int DW = $clog2((BASE_OE_TICKS << (PLANES - 1)) + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SETUP, CLKHI, BLANK, LATCH, DISPLAY} state_t;

`ifndef LEDPANEL_TEST_PATTERN_EN
  logic test_mode;
  assign test_mode = 1'b0;
`endif

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic tick;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d, abc_q, abc_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [DW-1:0] disp_q, disp_d, dur;
  logic [5:0][PLANES-1:0] hold_q;
  logic f_q, f_d, cap_q, done_q, done_d, test_q, test_d, shown;

  assign tick = cnt_q == CW'(SHIFT_DIV - 1);
  assign dur = DW'(BASE_OE_TICKS) << plane_q;

  // scan tick divider; every FSM transition waits for its last clk
  always_ff @(posedge clk) begin
    cnt_q <= (reset || tick) ? '0 : cnt_q + 1'b1;
  end

  // next-state logic: each state lasts one tick except DISPLAY, which lasts its plane weight
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    plane_d = plane_q;
    disp_d = disp_q;
    abc_d = abc_q;
    test_d = test_q;
    done_d = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: if (enable) begin
          row_d = '0;
          plane_d = '0;
          col_d = '0;
          test_d = test_mode;
          state_d = FETCH;
        end
        FETCH: state_d = SETUP;
        SETUP: state_d = CLKHI;
        CLKHI: begin
          state_d = &col_q ? BLANK : FETCH;
          col_d = &col_q ? col_q : col_q + 1'b1;
        end
        BLANK: begin
          state_d = LATCH;
          abc_d = row_q;
        end
        LATCH: begin
          state_d = DISPLAY;
          disp_d = '0;
        end
        DISPLAY: if (disp_q == dur - 1'b1) begin
          col_d = '0;
          state_d = FETCH;
          if (plane_q != PW'(PLANES - 1)) plane_d = plane_q + 1'b1;
          else begin
            plane_d = '0;
            row_d = row_q + 1'b1;
            if (&row_q) begin
              done_d = 1'b1;
              test_d = test_mode;
              state_d = enable ? FETCH : IDLE;
            end
          end
        end else disp_d = disp_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
    f_d = state_d == FETCH && state_q != FETCH;
  end

  // state registers; the pixel word is captured the clk after the fetch strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      plane_q <= '0;
      disp_q <= '0;
      abc_q <= '0;
      test_q <= 1'b0;
      done_q <= 1'b0;
      f_q <= 1'b0;
      cap_q <= 1'b0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      plane_q <= plane_d;
      disp_q <= disp_d;
      abc_q <= abc_d;
      test_q <= test_d;
      done_q <= done_d;
      f_q <= f_d;
      cap_q <= f_q;
      if (cap_q) hold_q <= test_q ? {6{col_q[PLANES-1:0]}} : rd_data;
    end
  end

  assign shown = state_q == SETUP || state_q == CLKHI;
  assign rd_en = f_q && !test_q;
  assign rd_addr = {row_q, col_q};
  assign frame_done = done_q;
  assign led_rgb1 = shown ? {hold_q[2][plane_q], hold_q[1][plane_q], hold_q[0][plane_q]} : 3'b000;
  assign led_rgb2 = shown ? {hold_q[5][plane_q], hold_q[4][plane_q], hold_q[3][plane_q]} : 3'b000;
  assign led_abc = abc_q;
  assign led_clk = state_q == CLKHI;
  assign led_latch = state_q == LATCH;
  assign led_oe = state_q != DISPLAY;
endmodule
